// File: rtl/y_signature_capture.sv
// Captures N samples of the wide y bus, XOR-folds each to SIG_W bits and compresses them into a MISR signature.
// Latency: start to done is N+1 clocks (start edge, then one edge per sample); N==0 reaches DONE one edge after start.
// No backpressure: y_in is sampled every RUN cycle; start is ignored while RUN. Optional golden compare: SIG_CMP_EN.
module y_signature_capture #(
    parameter int                 Y_W   = 686,
    parameter int                 SIG_W = 32,
    parameter int                 CNT_W = 16,
    parameter logic [SIG_W-1:0]   POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]   SEED  = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_cycles,
    input  logic [Y_W-1:0]      y_in,
`ifdef SIG_CMP_EN
    input  logic [SIG_W-1:0]    golden,
`endif
    output logic                busy,
    output logic                done,
    output logic [SIG_W-1:0]    signature,
    output logic [CNT_W-1:0]    cycles_done,
    output logic                mismatch
);

    localparam int NWORDS = (Y_W + SIG_W - 1) / SIG_W;
    localparam int PAD_W  = NWORDS * SIG_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   n_lat;
    logic [PAD_W-1:0]   padded;
    logic [SIG_W-1:0]   fold;
    logic [SIG_W-1:0]   misr_next;
    logic               accept;
    logic               last;

    // Zero-pad y_in to whole words and XOR all words together.
    always_comb begin
        padded = '0;
        padded[Y_W-1:0] = y_in;
        fold = '0;
        for (int k = 0; k < NWORDS; k++) begin
            fold = fold ^ padded[k*SIG_W +: SIG_W];
        end
    end

    // One MISR step: shift left, apply feedback on the outgoing MSB, inject the folded sample.
    always_comb begin
        misr_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ fold;
    end

    // Start is only honoured outside RUN; the last sample is the one that brings the count to N.
    always_comb begin
        accept = start && (state != S_RUN);
        last   = (state == S_RUN) && (cycles_done == n_lat - CNT_W'(1));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (num_cycles == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Signature, sample counter and latched run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature   <= '0;
            cycles_done <= '0;
            n_lat       <= '0;
        end else if (accept) begin
            signature   <= SEED;
            cycles_done <= '0;
            n_lat       <= num_cycles;
        end else if (state == S_RUN) begin
            signature   <= misr_next;
            cycles_done <= cycles_done + CNT_W'(1);
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

`ifdef SIG_CMP_EN
    // Compare against golden on the edge that enters DONE; cleared when a new run starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (accept) begin
            mismatch <= (num_cycles == '0) ? (SEED != golden) : 1'b0;
        end else if (last) begin
            mismatch <= (misr_next != golden);
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule
